mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction requests) and the memory stage (load/store requests) of the pipelined core.
- Grants one requester at a time and counts out the memory latency.
- Returns a one-cycle ready/data strobe to the granted requester.
- Drives the stall outputs that hold the pipeline registers.
- Honours a fetch flush from taken branches/jumps.

---
 rtl/arb_pkg.sv | 18 +
 rtl/mem_latency_timer.sv | 26 ++
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Wide enough for the largest legal latency reload value (15 - 1).
    localparam int CNT_W = $clog2(16);

endpackage

// File: rtl/mem_latency_timer.sv
// Load / decrement / zero-flag counter that times out the memory latency.
module mem_latency_timer
    import arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch and memory pipeline stages,
// with bounded data bursts so a pending fetch cannot starve.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_LATENCY    = 2,
    parameter int DATA_BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    input  logic                     flush_if,
    output logic                     if_ready,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    output logic                     d_ready,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     stall_f,
    output logic                     stall_m
);

    localparam int BW = $clog2(DATA_BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);

    arb_state_t       state, state_nxt;
    owner_t           owner;
    logic [BW-1:0]    burst_q, burst_nxt;
    logic             drop_q, drop_nxt;
    logic             we_q;
    logic             grant_if, grant_d, done, timer_zero;

    mem_latency_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_if | grant_d),
        .load_val (CNT_W'(MEM_LATENCY - 1)),
        .dec      (state != IDLE),
        .zero     (timer_zero)
    );

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_q;
        drop_nxt  = drop_q;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Grants are suppressed while reset is asserted so nothing leaks out.
                if (rst) begin
                    if (if_req && burst_q == BURST_MAX) grant_if = 1'b1;
                    else if (d_req)                     grant_d  = 1'b1;
                    else if (if_req)                    grant_if = 1'b1;
                end
                if (grant_if)      state_nxt = BUSY_IF;
                else if (grant_d)  state_nxt = BUSY_D;
                if (grant_if || !if_req)
                    burst_nxt = '0;
                else if (grant_d && burst_q != BURST_MAX)
                    burst_nxt = burst_q + 1'b1;
            end
            BUSY_IF: begin
                if (timer_zero) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b0;
                end else if (flush_if) begin
                    drop_nxt  = 1'b1;
                end
            end
            BUSY_D: begin
                if (timer_zero) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            burst_q <= '0;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            burst_q <= burst_nxt;
            drop_q  <= drop_nxt;
            if (grant_d) we_q <= d_we;
        end
    end

    assign owner    = (state == BUSY_IF) ? OWN_IF : OWN_D;
    assign done     = rst && (state != IDLE) && timer_zero;
    // A flush arriving in the completion cycle itself still kills the fetch.
    assign if_ready = done && owner == OWN_IF && !drop_q && !flush_if;
    assign d_ready  = done && owner == OWN_D;
    assign if_rdata = if_ready ? mem_rdata : '0;
    assign d_rdata  = (d_ready && !we_q) ? mem_rdata : '0;

    assign mem_req   = grant_if | grant_d;
    assign mem_we    = grant_d & d_we;
    assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
    assign mem_wdata = (grant_d && d_we) ? d_wdata : '0;

    assign stall_f = if_req & ~if_ready;
    assign stall_m = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int L    = 2;
    localparam int BMAX = 4;
    localparam logic [31:0] DBASE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, flush_if, if_ready;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ready;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_f, stall_m;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MEM_LATENCY   (L),
        .DATA_BURST_MAX(BMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .flush_if (flush_if),
        .if_ready (if_ready),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ready  (d_ready),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_f  (stall_f),
        .stall_m  (stall_m)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] faddr();
        return {16'h0000, 14'($urandom), 2'b00};
    endfunction

    // Environment memory: fixed latency, eight writable data words, fetch space is ROM.
    logic [31:0] ram_d [8];
    logic [7:0]  ram_v = '0;
    logic [31:0] rpipe [L];

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_addr[16]) begin
            ram_d[mem_addr[4:2]] <= mem_wdata;
            ram_v[mem_addr[4:2]] <= 1'b1;
        end
        if (mem_req && !mem_we)
            rpipe[0] <= (mem_addr[16] && ram_v[mem_addr[4:2]]) ? ram_d[mem_addr[4:2]] : hash(mem_addr);
        else
            rpipe[0] <= $urandom;
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];

    // Reference model state
    logic [31:0] fq[$];
    logic [31:0] dq[$];
    logic [31:0] model_d [8];
    bit   [7:0]  model_v = '0;
    bit          last_if_ready = 0;
    bit          last_d_ready  = 0;

    // Monitor: transaction-level view of the shared port.
    bit busy = 0, own_if = 0, flushed = 0;
    int g = 0, bcnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 0; bcnt = 0; flushed = 0;
            end else begin
                bit in_busy, exp_if, exp_r;
                logic [31:0] e;
                in_busy = busy && (cyc <= g + L);
                if (!in_busy) busy = 0;
                chk(!(if_ready && d_ready), "both_ready", {if_ready, d_ready}, 0);
                if (mem_req) begin
                    chk(!in_busy, "grant_while_busy", cyc, g + L + 1);
                    chk(if_req || d_req, "spurious_grant", mem_addr, 0);
                    exp_if = if_req && (bcnt == BMAX || !d_req);
                    chk(mem_addr == (exp_if ? if_addr : d_addr), "grant_addr", mem_addr, exp_if ? if_addr : d_addr);
                    chk(mem_we == (exp_if ? 1'b0 : d_we), "grant_we", mem_we, exp_if ? 1'b0 : d_we);
                    if (!exp_if && d_we) chk(mem_wdata == d_wdata, "grant_wdata", mem_wdata, d_wdata);
                    busy = 1; g = cyc; own_if = exp_if; flushed = 0;
                    if (exp_if || !if_req) bcnt = 0;
                    else if (bcnt < BMAX) bcnt++;
                end else if (!in_busy) begin
                    chk(!(if_req || d_req), "missed_grant", {if_req, d_req}, 0);
                    if (!if_req) bcnt = 0;
                end
                if (in_busy && cyc == g + L) begin
                    if (own_if) begin
                        exp_r = !(flushed || flush_if);
                        chk(if_ready == exp_r, "if_ready", if_ready, exp_r);
                        chk(!d_ready, "d_ready_on_fetch", d_ready, 0);
                        if (if_ready) begin
                            if (fq.size() == 0) chk(0, "if_unexpected", if_rdata, 0);
                            else begin
                                e = fq.pop_front();
                                chk(if_rdata == e, "if_rdata", if_rdata, e);
                            end
                        end
                    end else begin
                        chk(d_ready, "d_ready", d_ready, 1);
                        chk(!if_ready, "if_ready_on_data", if_ready, 0);
                        if (d_ready) begin
                            if (dq.size() == 0) chk(0, "d_unexpected", d_rdata, 0);
                            else begin
                                e = dq.pop_front();
                                chk(d_rdata == e, "d_rdata", d_rdata, e);
                            end
                        end
                    end
                end else begin
                    chk(!if_ready && !d_ready, "ready_off_completion", {if_ready, d_ready}, 0);
                end
                if (in_busy && own_if && cyc > g && flush_if) flushed = 1;
                if (!if_ready) chk(if_rdata == 0, "if_rdata_idle", if_rdata, 0);
                if (!d_ready)  chk(d_rdata == 0, "d_rdata_idle", d_rdata, 0);
                chk(stall_f == (if_req && !if_ready), "stall_f", stall_f, if_req && !if_ready);
                chk(stall_m == (d_req && !d_ready), "stall_m", stall_m, d_req && !d_ready);
            end
            last_if_ready = if_ready;
            last_d_ready  = d_ready;
        end
    end

    // One cycle of requester behaviour; expectations are queued at issue time.
    task automatic drive_cycle(input bit allow_new, input int dmod);
        int idx;
        @(posedge clk); #1;
        flush_if = 1'b0;
        if (if_req && last_if_ready) if_req = 1'b0;
        else if (if_req && allow_new && $urandom_range(11) == 0) begin
            flush_if = 1'b1;
            if_addr  = faddr();
            if (fq.size() > 0) fq.delete(fq.size() - 1);
            fq.push_back(hash(if_addr));
        end
        if (!if_req && allow_new && $urandom_range(2) == 0) begin
            if_req  = 1'b1;
            if_addr = faddr();
            fq.push_back(hash(if_addr));
        end
        if (d_req && last_d_ready) d_req = 1'b0;
        if (!d_req && allow_new && $urandom_range(dmod - 1) == 0) begin
            idx     = int'($urandom_range(7));
            d_req   = 1'b1;
            d_addr  = DBASE | (idx << 2);
            d_we    = 1'($urandom_range(1));
            d_wdata = $urandom;
            if (d_we) begin
                model_d[idx] = d_wdata;
                model_v[idx] = 1'b1;
                dq.push_back(32'h0);
            end else begin
                dq.push_back(model_v[idx] ? model_d[idx] : hash(d_addr));
            end
        end
    endtask

    initial begin
        rst = 1'b0; if_req = 0; if_addr = '0; flush_if = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset in the middle of a fetch abandons it silently.
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h0000_0004;
        @(negedge clk);
        chk(mem_req == 1'b1, "rst_pre_grant", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk(!if_ready && !d_ready, "rst_no_ready", {if_ready, d_ready}, 0);
        chk(!mem_req && mem_addr == 0 && !mem_we && mem_wdata == 0, "rst_mem_idle", mem_addr, 0);
        chk(if_rdata == 0 && d_rdata == 0, "rst_rdata", if_rdata | d_rdata, 0);
        chk(!stall_f && !stall_m, "rst_stalls", {stall_f, stall_m}, 0);

        for (int i = 0; i < 1500; i++) drive_cycle(1'b1, 3);
        // Data re-requests every time so the burst limit is exercised.
        for (int i = 0; i < 1500; i++) drive_cycle(1'b1, 1);
        for (int i = 0; i < 300 && (if_req || d_req); i++) drive_cycle(1'b0, 1);
        repeat (L + 2) @(posedge clk);
        @(negedge clk);
        chk(!if_req && !d_req && fq.size() == 0 && dq.size() == 0, "drain",
            32'(fq.size() + dq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
